// File: rtl/core_pkg.sv
// Shared core definitions: memory port identifiers and default memory geometry.
package core_pkg;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } mem_port_e;

    localparam int unsigned CORE_ADDR_WIDTH = 12;
    localparam int unsigned CORE_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. Bit 0 is the fetch port, bit 1 the load/store port.
module rr_arbiter2
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    mem_port_e last_winner_q;
    mem_port_e last_winner_d;

    // Priority only rotates on contention; a lone requester does not disturb it.
    always_comb begin
        gnt_o         = '0;
        last_winner_d = last_winner_q;
        if (!rst) begin
            unique case (req_i)
                2'b01: gnt_o = 2'b01;
                2'b10: gnt_o = 2'b10;
                2'b11: begin
                    if (last_winner_q == PORT_IF) begin
                        gnt_o         = 2'b10;
                        last_winner_d = PORT_LS;
                    end else begin
                        gnt_o         = 2'b01;
                        last_winner_d = PORT_IF;
                    end
                end
                default: gnt_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= PORT_IF;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store,
// routing each read response back to its owner one cycle after the grant.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CORE_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic [CNT_WIDTH-1:0]    conflict_cnt
);

    logic [1:0]           gnt;
    logic                 rsp_valid_q;
    logic                 rsp_valid_d;
    mem_port_e            rsp_owner_q;
    mem_port_e            rsp_owner_d;
    logic [CNT_WIDTH-1:0] conflict_q;
    logic [CNT_WIDTH-1:0] conflict_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({ls_req, if_req}),
        .gnt_o (gnt)
    );

    assign if_gnt = gnt[0];
    assign ls_gnt = gnt[1];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = if_addr;
        mem_wdata = ls_wdata;
        if (ls_gnt) begin
            mem_en   = 1'b1;
            mem_addr = ls_addr;
            if (ls_we) begin
                mem_we = ls_be;
            end
        end else if (if_gnt) begin
            mem_en = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = if_gnt | (ls_gnt & ~ls_we);
        rsp_owner_d = ls_gnt ? PORT_LS : PORT_IF;
    end

    always_comb begin
        conflict_d = conflict_q;
        if (if_req && ls_req && (conflict_q != '1)) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= PORT_IF;
            conflict_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            conflict_q  <= conflict_d;
        end
    end

    // Gating with rst keeps a response from the cycle before reset from surfacing.
    assign if_rvalid    = rsp_valid_q && !rst && (rsp_owner_q == PORT_IF);
    assign ls_rvalid    = rsp_valid_q && !rst && (rsp_owner_q == PORT_LS);
    assign if_rdata     = mem_rdata;
    assign ls_rdata     = mem_rdata;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, randomized traffic against a
// transaction-level reference model, and a counter saturation sequence.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          ls_req;
    logic          ls_we;
    logic [BW-1:0] ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] mem_rdata;

    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en;
    logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   conflict_cnt;

    logic          if_gnt4, if_rvalid4, ls_gnt4, ls_rvalid4, mem_en4;
    logic [DW-1:0] if_rdata4, ls_rdata4, mem_wdata4;
    logic [BW-1:0] mem_we4;
    logic [AW-1:0] mem_addr4;
    logic [3:0]    conflict_cnt4;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt4),
        .if_rvalid(if_rvalid4), .if_rdata(if_rdata4),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt4), .ls_rvalid(ls_rvalid4), .ls_rdata(ls_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt4)
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {4'h5, a, 4'hA, ~a};
    endfunction

    // Memory attached to the main DUT's port.
    bit [DW-1:0] mem   [4096];
    bit          mem_wr[4096];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
            if (mem_we != '0) begin
                logic [DW-1:0] w;
                w = mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
                for (int b = 0; b < BW; b++)
                    if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr]    <= w;
                mem_wr[mem_addr] <= 1'b1;
            end
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: round-robin state, one outstanding response, model memory.
    int          lw = 0;
    bit          pv = 0;
    int          powner = 0;
    logic [31:0] pdata = '0;
    int unsigned mcnt = 0, mcnt4 = 0;
    bit          m_eig, m_elg;
    bit [31:0]   mmem[4096];
    bit          mwr[4096];

    function automatic logic [31:0] mread(input logic [11:0] a);
        return mwr[a] ? mmem[a] : init_val(a);
    endfunction

    task automatic model_check();
        bit eirv, elrv;
        logic [BW-1:0] ewe;
        m_eig = 0;
        m_elg = 0;
        if (!rst) begin
            if (if_req && ls_req) begin
                if (lw == 0) m_elg = 1; else m_eig = 1;
            end else if (if_req) m_eig = 1;
            else if (ls_req) m_elg = 1;
        end
        ewe = (m_elg && ls_we) ? ls_be : '0;
        chk("if_gnt", if_gnt, m_eig);
        chk("ls_gnt", ls_gnt, m_elg);
        chk("mem_en", mem_en, m_eig | m_elg);
        chk("mem_we", mem_we, ewe);
        if (m_eig || m_elg) chk("mem_addr", mem_addr, m_elg ? ls_addr : if_addr);
        if (ewe != '0) chk("mem_wdata", mem_wdata, ls_wdata);
        eirv = pv && powner == 0 && !rst;
        elrv = pv && powner == 1 && !rst;
        chk("if_rvalid", if_rvalid, eirv);
        chk("ls_rvalid", ls_rvalid, elrv);
        if (eirv) chk("if_rdata", if_rdata, pdata);
        if (elrv) chk("ls_rdata", ls_rdata, pdata);
        chk("conflict_cnt", conflict_cnt, mcnt);
        chk("conflict_cnt4", conflict_cnt4, mcnt4);
        chk("if_gnt4", if_gnt4, m_eig);
        chk("ls_gnt4", ls_gnt4, m_elg);
    endtask

    task automatic model_advance();
        logic [31:0] w;
        if (rst) begin
            lw = 0; pv = 0; mcnt = 0; mcnt4 = 0;
        end else begin
            if (if_req && ls_req) begin
                lw = m_elg ? 1 : 0;
                if (mcnt < 65535) mcnt++;
                if (mcnt4 < 15) mcnt4++;
            end
            pv     = m_eig || (m_elg && !ls_we);
            powner = m_elg ? 1 : 0;
            if (m_eig) begin
                pdata = mread(if_addr);
            end else if (m_elg) begin
                pdata = mread(ls_addr);
                if (ls_we) begin
                    w = mread(ls_addr);
                    for (int b = 0; b < BW; b++)
                        if (ls_be[b]) w[8*b +: 8] = ls_wdata[8*b +: 8];
                    mmem[ls_addr] = w;
                    mwr[ls_addr]  = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    typedef struct {
        logic        rst, ifr, lsr, we;
        logic [3:0]  be;
        logic [11:0] ia, la;
        logic [31:0] wd;
        logic        eig, elg;
        logic [3:0]  ewe;
        logic        eirv, elrv;
        logic [15:0] ecnt;
        int          rsel;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mkv(
        input logic r, input logic ifr, input logic lsr, input logic we, input logic [3:0] be,
        input logic [11:0] ia, input logic [11:0] la, input logic [31:0] wd,
        input logic eig, input logic elg, input logic [3:0] ewe, input logic eirv,
        input logic elrv, input logic [15:0] ecnt, input int rsel, input logic [31:0] erd);
        vec_t v;
        v.rst = r; v.ifr = ifr; v.lsr = lsr; v.we = we; v.be = be; v.ia = ia; v.la = la;
        v.wd = wd; v.eig = eig; v.elg = elg; v.ewe = ewe; v.eirv = eirv; v.elrv = elrv;
        v.ecnt = ecnt; v.rsel = rsel; v.erd = erd;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        logic [31:0] st20;
        st20 = (init_val(12'h020) & 32'hFFFF0000) | 32'h00005678;
        //              rst ifr lsr we be    ia       la       wd            eig elg ewe   irv lrv cnt rsel erd
        tbl[0]  = mkv(1, 1, 1, 0, 4'h0, 12'h010, 12'h030, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 1, 1, 0, 4'h0, 12'h010, 12'h030, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 1, 0, 4'h0, 12'h010, 12'h030, 32'h0,        0, 1, 4'h0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(0, 1, 1, 0, 4'h0, 12'h010, 12'h030, 32'h0,        1, 0, 4'h0, 0, 1, 1, 2, init_val(12'h030));
        tbl[4]  = mkv(0, 1, 1, 0, 4'h0, 12'h010, 12'h030, 32'h0,        0, 1, 4'h0, 1, 0, 2, 1, 32'hDEADBEEF);
        tbl[5]  = mkv(0, 1, 1, 0, 4'h0, 12'h010, 12'h030, 32'h0,        1, 0, 4'h0, 0, 1, 3, 2, init_val(12'h030));
        tbl[6]  = mkv(0, 0, 0, 0, 4'h0, 12'h000, 12'h000, 32'h0,        0, 0, 4'h0, 1, 0, 4, 1, 32'hDEADBEEF);
        tbl[7]  = mkv(0, 1, 0, 0, 4'h0, 12'h010, 12'h000, 32'h0,        1, 0, 4'h0, 0, 0, 4, 0, 0);
        tbl[8]  = mkv(0, 0, 0, 0, 4'h0, 12'h000, 12'h000, 32'h0,        0, 0, 4'h0, 1, 0, 4, 1, 32'hDEADBEEF);
        tbl[9]  = mkv(0, 0, 1, 1, 4'h3, 12'h000, 12'h020, 32'h12345678, 0, 1, 4'h3, 0, 0, 4, 0, 0);
        tbl[10] = mkv(0, 0, 1, 0, 4'h0, 12'h000, 12'h020, 32'h0,        0, 1, 4'h0, 0, 0, 4, 0, 0);
        tbl[11] = mkv(0, 0, 0, 0, 4'h0, 12'h000, 12'h000, 32'h0,        0, 0, 4'h0, 0, 1, 4, 2, st20);
        tbl[12] = mkv(0, 1, 0, 0, 4'h0, 12'h010, 12'h000, 32'h0,        1, 0, 4'h0, 0, 0, 4, 0, 0);
        tbl[13] = mkv(1, 0, 0, 0, 4'h0, 12'h000, 12'h000, 32'h0,        0, 0, 4'h0, 0, 0, 4, 0, 0);
        tbl[14] = mkv(0, 0, 0, 0, 4'h0, 12'h000, 12'h000, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 0);
        tbl[15] = mkv(0, 0, 0, 0, 4'h0, 12'h000, 12'h000, 32'h0,        0, 0, 4'h0, 0, 0, 0, 0, 0);

        rst = 1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0;
        ls_be = '0; ls_addr = '0; ls_wdata = '0;

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; if_req = tbl[i].ifr; ls_req = tbl[i].lsr; ls_we = tbl[i].we;
            ls_be = tbl[i].be; if_addr = tbl[i].ia; ls_addr = tbl[i].la; ls_wdata = tbl[i].wd;
            @(negedge clk);
            chk($sformatf("v%0d.if_gnt", i), if_gnt, tbl[i].eig);
            chk($sformatf("v%0d.ls_gnt", i), ls_gnt, tbl[i].elg);
            chk($sformatf("v%0d.mem_en", i), mem_en, tbl[i].eig | tbl[i].elg);
            chk($sformatf("v%0d.mem_we", i), mem_we, tbl[i].ewe);
            chk($sformatf("v%0d.if_rvalid", i), if_rvalid, tbl[i].eirv);
            chk($sformatf("v%0d.ls_rvalid", i), ls_rvalid, tbl[i].elrv);
            chk($sformatf("v%0d.conflict_cnt", i), conflict_cnt, tbl[i].ecnt);
            if (tbl[i].rsel == 1) chk($sformatf("v%0d.if_rdata", i), if_rdata, tbl[i].erd);
            if (tbl[i].rsel == 2) chk($sformatf("v%0d.ls_rdata", i), ls_rdata, tbl[i].erd);
            model_check();
            @(posedge clk);
            model_advance();
            #1;
        end

        // Randomized traffic obeying the hold-until-grant handshake, with occasional drops and resets.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(49) == 0);
            if (!(if_req && !m_eig && $urandom_range(9) != 0)) begin
                if_req  = $urandom_range(1);
                if_addr = 12'($urandom_range(63));
            end
            if (!(ls_req && !m_elg && $urandom_range(9) != 0)) begin
                ls_req   = $urandom_range(1);
                ls_we    = $urandom_range(1);
                ls_be    = 4'($urandom);
                ls_addr  = 12'($urandom_range(63));
                ls_wdata = $urandom;
            end
            tick();
        end

        // Constant contention after reset: the 4-bit counter must stick at 15.
        rst = 1; if_req = 1; ls_req = 1; ls_we = 0; if_addr = 12'h005; ls_addr = 12'h006;
        tick();
        rst = 0;
        for (int n = 0; n < 20; n++) tick();
        if_req = 0; ls_req = 0;
        @(negedge clk);
        chk("sat_cnt4", conflict_cnt4, 32'd15);
        chk("cnt16_after20", conflict_cnt, 32'd20);
        model_check();
        @(posedge clk);
        model_advance();
        #1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares the core's single-port synchronous program/data memory between the instruction-fetch port and the load/store port. Arbitrates each cycle, drives the memory control signals, and routes the read response back to the requester that owns it one cycle later. Sits inside `riscv_core` between the fetch/LSU stages and the memory instance loaded from the test program image.

## Interface

Parameters:
- `ADDR_WIDTH`, 12, word-address width of the memory.
- `DATA_WIDTH`, 32, data word width; byte-enable width is `DATA_WIDTH/8`.
- `CNT_WIDTH`, 16, width of the contention counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous reset, active-high.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  ADDR_WIDTH  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  DATA_WIDTH  fetch read data.
- `ls_req`  in  1  load/store request; held until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_be`  in  DATA_WIDTH/8  store byte enables.
- `ls_addr`  in  ADDR_WIDTH  load/store word address.
- `ls_wdata`  in  DATA_WIDTH  store data.
- `ls_gnt`  out  1  load/store request accepted this cycle.
- `ls_rvalid`  out  1  load data valid; never asserted for stores.
- `ls_rdata`  out  DATA_WIDTH  load data.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  DATA_WIDTH/8  per-byte write enables.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid one cycle after a read enable.
- `conflict_cnt`  out  CNT_WIDTH  saturating count of cycles with both requests active.

## Operation

- Grant logic is combinational from the requests and the `last_winner` register (one bit: IF or LS).
- At most one grant per cycle.
- Only one request active: that requester is granted.
- Both active: the port that is not `last_winner` is granted (round-robin). `last_winner` updates only on conflict cycles.
- On a grant, the memory signals are driven as follows:
  - `mem_en` = 1.
  - `mem_addr` comes from the winner.
  - `mem_we` = `ls_be` for an LS store, otherwise 0.
  - `mem_wdata` = `ls_wdata`.
- No grant: `mem_en` = 0 and `mem_we` = 0.
- Response tracking: registers `rsp_valid` and `rsp_owner` capture "read granted" and the winner.
  - The next cycle, `<owner>_rvalid` = `rsp_valid`.
  - Both `if_rdata` and `ls_rdata` pass `mem_rdata` through combinationally. They are meaningful only while the matching rvalid is high.
- Back-to-back grants are allowed every cycle. Full throughput is one access per cycle.
- `conflict_cnt` increments on every cycle with `if_req && ls_req` (with `rst` low) and saturates at all-ones.

## Timing

- Reset values:
  - `last_winner` = IF, so the first conflict grants LS.
  - `rsp_valid` = 0 and `conflict_cnt` = 0.
  - `if_rvalid` = 0 and `ls_rvalid` = 0.
  - While `rst` is high, `if_gnt`, `ls_gnt`, `mem_en` and `mem_we` are forced to 0.
  - `mem_addr`, `mem_wdata` and the rdata outputs are don't-care during reset.
- Latency:
  - Grant occurs in the same cycle as the request (zero-cycle arbitration).
  - Read data arrives on the cycle after the grant (rvalid = 1 at grant+1).
  - A store completes at its grant edge.
- Handshake: a requester must hold its request and payload stable until it sees gnt high. Dropping a request before the grant is legal, and the request is simply not serviced.
- Reset mid-operation: a read granted in the cycle before `rst` asserts produces no rvalid, because `rsp_valid` clears on reset. No rvalid appears in the first cycle after `rst` deasserts.
- A loser in a conflict cycle is granted on the next cycle if it still requests, since `last_winner` now favours it.
- An LS store followed by an LS load to the same address on the next cycle returns the new data (memory write-first is not required, because the accesses happen on different cycles).

## Structure

- Shared package `core_pkg`:
  - enum `mem_port_e` {`PORT_IF`, `PORT_LS`}, used for `last_winner` and `rsp_owner`.
  - default width constants for ADDR and DATA.
- One sub-module, `rr_arbiter2`: two-request round-robin with a `last_winner` flop and a grant vector output. The top level adds muxing, response tracking and the counter.

## Test plan

- Reset, with `if_req`=1 and `ls_req`=1 held during reset: no gnt and no `mem_en` while `rst`=1. In the first cycle after reset, `ls_gnt`=1 and `conflict_cnt` increments to 1.
- IF-only read at 0x010 with `mem_rdata`=0xDEADBEEF: `if_gnt` in the same cycle, `mem_en`=1, `mem_addr`=0x010. Next cycle `if_rvalid`=1 and `if_rdata`=0xDEADBEEF, with `ls_rvalid`=0.
- LS store to 0x020, `be`=0b0011, `wdata`=0x12345678: `mem_we`=0b0011 on the grant cycle, and no `ls_rvalid` on the next cycle.
- Both requesting for 4 cycles: grants alternate LS, IF, LS, IF. Each rvalid goes to the correct owner one cycle later, and `conflict_cnt` rises by 4.
- Assert `rst` for one cycle immediately after an IF read grant: `if_rvalid` stays 0 through and after reset.
- `CNT_WIDTH`=4 with constant conflict for 20 cycles: `conflict_cnt` saturates at 15 and holds there.
